// File: rtl/muldiv_sequencer_if.sv
// Controller <-> RV32M multiply/divide sequencer handshake and operand/result bus.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start_;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            flush_;
    logic            stall_;
    logic            done_;
    logic [XLEN-1:0] result_;

    // Controller side: issues ops and flushes, watches stall/done/result.
    modport master (
        output start_, funct3, rs1_value, rs2_value, flush_,
        input  stall_, done_, result_
    );

    // Execution unit side.
    modport slave (
        input  start_, funct3, rs1_value, rs2_value, flush_,
        output stall_, done_, result_
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution unit: fixed-latency multiply, iterative restoring divide.
// Stalls the pipeline while busy and pulses done_ for one cycle with the result.
module muldiv_sequencer #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave mdu
);
    localparam int unsigned CntMax = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] result_q, result_d;

    // Request decode in IDLE.
    logic            accept;
    logic            in_signed;
    logic            in_div_zero;
    logic            in_overflow;
    logic            in_special;
    logic [XLEN-1:0] in_special_res;
    logic [XLEN-1:0] in_dividend_mag;

    // Multiply datapath.
    logic            mul_a_sx, mul_b_sx;
    logic [XLEN:0]   mul_a_ext, mul_b_ext;
    logic [2*XLEN-1:0] mul_a_wide, mul_b_wide, mul_prod;
    logic [XLEN-1:0] mul_res;

    // Divide datapath.
    logic            div_signed;
    logic            q_neg, r_neg;
    logic [XLEN-1:0] div_mag;
    logic [XLEN:0]   div_trial, div_diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_step, quo_step;
    logic [XLEN-1:0] div_res;

    logic stall, done;

    // Request decode and divide special-case detection on the incoming operands.
    always_comb begin
        accept          = (state_q == StIdle) && mdu.start_ && !mdu.flush_;
        in_signed       = ~mdu.funct3[0];
        in_div_zero     = (mdu.rs2_value == '0);
        in_overflow     = in_signed && (mdu.rs1_value == {1'b1, {(XLEN-1){1'b0}}})
                          && (mdu.rs2_value == '1);
        in_special      = in_div_zero || in_overflow;
        // funct3[1] selects remainder; overflow quotient equals rs1 (the most negative value).
        if (mdu.funct3[1]) begin
            in_special_res = in_div_zero ? mdu.rs1_value : '0;
        end else begin
            in_special_res = in_div_zero ? '1 : mdu.rs1_value;
        end
        in_dividend_mag = (in_signed && mdu.rs1_value[XLEN-1]) ? -mdu.rs1_value : mdu.rs1_value;
    end

    // Multiply: extend to XLEN+1 by op signedness, then to 2*XLEN; low 2*XLEN bits are exact.
    always_comb begin
        mul_a_sx   = (funct3_q[1:0] != 2'b11);
        mul_b_sx   = (funct3_q[1:0] == 2'b01);
        mul_a_ext  = {mul_a_sx & op_a_q[XLEN-1], op_a_q};
        mul_b_ext  = {mul_b_sx & op_b_q[XLEN-1], op_b_q};
        mul_a_wide = {{(XLEN-1){mul_a_ext[XLEN]}}, mul_a_ext};
        mul_b_wide = {{(XLEN-1){mul_b_ext[XLEN]}}, mul_b_ext};
        mul_prod   = mul_a_wide * mul_b_wide;
        mul_res    = (funct3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Divide: one restoring step on magnitudes; quo_q shifts dividend out and quotient in.
    always_comb begin
        div_signed = ~funct3_q[0];
        q_neg      = div_signed && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1]);
        r_neg      = div_signed && op_a_q[XLEN-1];
        div_mag    = (div_signed && op_b_q[XLEN-1]) ? -op_b_q : op_b_q;
        div_trial  = {rem_q, quo_q[XLEN-1]};
        div_diff   = div_trial - {1'b0, div_mag};
        q_bit      = ~div_diff[XLEN];
        rem_step   = q_bit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
        quo_step   = {quo_q[XLEN-2:0], q_bit};
        if (funct3_q[1]) begin
            div_res = r_neg ? -rem_step : rem_step;
        end else begin
            div_res = q_neg ? -quo_step : quo_step;
        end
    end

    // State and datapath registers; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            funct3_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; flush_ returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!mdu.funct3[2]) begin
                        state_d = StMul;
                    end else if (in_special) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StMul:   if (cnt_q == '0) state_d = StDone;
            StDiv:   if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (mdu.flush_) begin
            state_d = StIdle;
        end
    end

    // Datapath next values; result_ only loads on a non-flushed transition into DONE.
    always_comb begin
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    funct3_d = mdu.funct3;
                    op_a_d   = mdu.rs1_value;
                    op_b_d   = mdu.rs2_value;
                    rem_d    = '0;
                    quo_d    = in_dividend_mag;
                    cnt_d    = mdu.funct3[2] ? CntW'(XLEN - 1) : CntW'(MUL_LAT - 1);
                    if (mdu.funct3[2] && in_special) begin
                        result_d = in_special_res;
                    end
                end
            end
            StMul: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!mdu.flush_) begin
                    result_d = mul_res;
                end
            end
            StDiv: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!mdu.flush_) begin
                    result_d = div_res;
                end
            end
            default: ;
        endcase
    end

    // Outputs: stall while busy or accepting; done_ only in DONE.
    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            StIdle:  stall = accept;
            StMul:   stall = 1'b1;
            StDiv:   stall = 1'b1;
            StDone:  done  = 1'b1;
            default: ;
        endcase
    end

    assign mdu.stall_  = stall;
    assign mdu.done_   = done;
    assign mdu.result_ = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_sequencer_if #(.XLEN(32)) mdu ();

    muldiv_sequencer #(
        .XLEN   (32),
        .MUL_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mdu(mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge with the unit idle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        int   n;
        logic stall_ok;
        mdu.funct3    = f3;
        mdu.rs1_value = a;
        mdu.rs2_value = b;
        mdu.start_    = 1'b1;
        #1;
        check({tag, " stall@start"}, {31'b0, mdu.stall_}, 32'd1);
        @(negedge clk);
        mdu.start_ = 1'b0;
        n          = 1;
        stall_ok   = 1'b1;
        while (mdu.done_ !== 1'b1 && n < 100) begin
            if (mdu.stall_ !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " result"}, mdu.result_, exp_res);
        check({tag, " stall@done"}, {31'b0, mdu.stall_}, 32'd0);
        check({tag, " stall while busy"}, {31'b0, stall_ok}, 32'd1);
        @(negedge clk);
        check({tag, " done pulse width"}, {31'b0, mdu.done_}, 32'd0);
        check({tag, " result held"}, mdu.result_, exp_res);
    endtask

    initial begin
        bit seen_done;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        mdu.start_    = 1'b0;
        mdu.flush_    = 1'b0;
        mdu.funct3    = 3'b000;
        mdu.rs1_value = '0;
        mdu.rs2_value = '0;
        repeat (2) @(negedge clk);
        check("reset stall", {31'b0, mdu.stall_}, 32'd0);
        check("reset done", {31'b0, mdu.done_}, 32'd0);
        check("reset result", mdu.result_, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Multiply.
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3, "mul 7*-3");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, "mulhu");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "mulhsu");
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3, "mulh -1*-1");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3, "mulh min*min");

        // Divide / remainder.
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div -7/2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem -7%2");
        run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div 7/-2");
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem 7%-2");
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu 100/7");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu 100%7");

        // Flush during DIV cycle 10, then restart in the very next cycle.
        mdu.funct3    = 3'b101;
        mdu.rs1_value = 32'd100;
        mdu.rs2_value = 32'd7;
        mdu.start_    = 1'b1;
        @(negedge clk);
        mdu.start_ = 1'b0;
        repeat (9) @(negedge clk);
        mdu.flush_ = 1'b1;
        @(negedge clk);
        mdu.flush_ = 1'b0;
        #1;
        check("flush stall", {31'b0, mdu.stall_}, 32'd0);
        check("flush done", {31'b0, mdu.done_}, 32'd0);
        check("flush result kept", mdu.result_, 32'd2);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu after flush");

        // Divide special cases.
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu 5/0");
        run_op(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem 5/0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem ovf");
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu min/max");

        // start_ together with flush_ is ignored.
        run_op(3'b000, 32'd3, 32'd5, 32'd15, 3, "mul 3*5");
        mdu.funct3    = 3'b000;
        mdu.rs1_value = 32'd9;
        mdu.rs2_value = 32'd9;
        mdu.start_    = 1'b1;
        mdu.flush_    = 1'b1;
        #1;
        check("start+flush stall", {31'b0, mdu.stall_}, 32'd0);
        @(negedge clk);
        mdu.start_ = 1'b0;
        mdu.flush_ = 1'b0;
        seen_done  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (mdu.done_ === 1'b1 || mdu.stall_ === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        check("start+flush no activity", {31'b0, seen_done}, 32'd0);
        check("start+flush result kept", mdu.result_, 32'd15);

        // Reset mid-MUL clears everything and suppresses done_.
        mdu.funct3    = 3'b011;
        mdu.rs1_value = 32'hFFFF_FFFF;
        mdu.rs2_value = 32'hFFFF_FFFF;
        mdu.start_    = 1'b1;
        @(negedge clk);
        mdu.start_ = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst mid-mul stall", {31'b0, mdu.stall_}, 32'd0);
        check("rst mid-mul done", {31'b0, mdu.done_}, 32'd0);
        check("rst mid-mul result", mdu.result_, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mdu.done_ === 1'b1) seen_done = 1'b1;
        end
        check("rst mid-mul no done", {31'b0, seen_done}, 32'd0);
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3, "mul after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
